q_update_ctrl: RTL

//  Q-learning update engine that drives the action-value RAM read/write port.
//  Per accepted transition (s, a, r, s') it reads Q(s,a) and all Q(s',*), finds

---
 rtl/q_update_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/q_update_ctrl.sv
// Q-learning update engine: reads Q(s,a) and Q(s',*), finds max/argmax over s',
// applies Q += ALPHA*(r + GAMMA*maxQ - Q) with saturation and writes the result back.
module q_update_ctrl #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    FRAC_BITS     = 8,
  parameter int                    STATES        = 64,
  parameter int                    STATES_WIDTH  = 6,
  parameter int                    ACTIONS       = 4,
  parameter int                    ACTIONS_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] ALPHA         = 16'h0080,
  parameter logic [DATA_WIDTH-1:0] GAMMA         = 16'h00E6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [STATES_WIDTH-1:0]       i_st,
  input  logic [ACTIONS_WIDTH-1:0]      i_at,
  input  logic [STATES_WIDTH-1:0]       i_next_st,
  input  logic [DATA_WIDTH-1:0]         i_reward,
  output logic                          o_done,
  output logic [ACTIONS_WIDTH-1:0]      o_best_at,
  output logic                          o_ram_re,
  output logic                          o_ram_we,
  output logic [ACTIONS_WIDTH-1:0]      o_ram_at,
  output logic [STATES_WIDTH-1:0]       o_ram_st,
  output logic [STATES_WIDTH-1:0]       o_ram_next_st,
  output logic [DATA_WIDTH-1:0]         o_ram_data,
  input  logic [DATA_WIDTH-1:0]         i_ram_q,
  input  logic [DATA_WIDTH*ACTIONS-1:0] i_ram_next_q
);

  // Wide enough that ALPHA*td cannot overflow for any parameter values.
  localparam int WW = 3 * DATA_WIDTH + 4;
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

  if (STATES > (1 << STATES_WIDTH) || ACTIONS < 2 || ACTIONS > (1 << ACTIONS_WIDTH)) begin : g_param_check
    $error("q_update_ctrl: index widths too small for STATES/ACTIONS");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_MAX, S_CALC, S_WRITE} state_t;

  state_t                         state_q, state_d;
  logic [STATES_WIDTH-1:0]        st_q, st_d, next_st_q, next_st_d;
  logic [ACTIONS_WIDTH-1:0]       at_q, at_d;
  logic signed [DATA_WIDTH-1:0]   reward_q, reward_d;
  logic signed [DATA_WIDTH-1:0]   cur_q_q, cur_q_d;
  logic signed [DATA_WIDTH-1:0]   next_q_q [ACTIONS];
  logic signed [DATA_WIDTH-1:0]   next_q_d [ACTIONS];
  logic signed [DATA_WIDTH-1:0]   max_q, max_d;
  logic [ACTIONS_WIDTH-1:0]       best_q, best_d, idx_q, idx_d;
  logic [ACTIONS_WIDTH-1:0]       best_out_q, best_out_d;
  logic [DATA_WIDTH-1:0]          data_q, data_d;
  logic                           done_q, done_d;

  logic signed [WW-1:0] q_ext, r_ext, max_ext, gamma_ext, alpha_ext;
  logic signed [WW-1:0] gprod, td, aprod, nq_wide;
  logic [DATA_WIDTH-1:0] nq_sat;

  // Update arithmetic: operands sign-extended, ALPHA/GAMMA zero-extended (unsigned).
  always_comb begin
    q_ext     = {{(WW-DATA_WIDTH){cur_q_q[DATA_WIDTH-1]}}, cur_q_q};
    r_ext     = {{(WW-DATA_WIDTH){reward_q[DATA_WIDTH-1]}}, reward_q};
    max_ext   = {{(WW-DATA_WIDTH){max_q[DATA_WIDTH-1]}}, max_q};
    gamma_ext = {{(WW-DATA_WIDTH){1'b0}}, GAMMA};
    alpha_ext = {{(WW-DATA_WIDTH){1'b0}}, ALPHA};
    gprod     = gamma_ext * max_ext;
    td        = r_ext + (gprod >>> FRAC_BITS) - q_ext;
    aprod     = alpha_ext * td;
    nq_wide   = q_ext + (aprod >>> FRAC_BITS);
    if (nq_wide > SAT_MAX)      nq_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (nq_wide < SAT_MIN) nq_sat = SAT_MIN[DATA_WIDTH-1:0];
    else                        nq_sat = nq_wide[DATA_WIDTH-1:0];
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    st_d       = st_q;
    at_d       = at_q;
    next_st_d  = next_st_q;
    reward_d   = reward_q;
    cur_q_d    = cur_q_q;
    next_q_d   = next_q_q;
    max_d      = max_q;
    best_d     = best_q;
    idx_d      = idx_q;
    data_d     = data_q;
    best_out_d = best_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          st_d      = i_st;
          at_d      = i_at;
          next_st_d = i_next_st;
          reward_d  = i_reward;
          state_d   = S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        cur_q_d = i_ram_q;
        for (int k = 0; k < ACTIONS; k++) begin
          next_q_d[k] = i_ram_next_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
        max_d   = i_ram_next_q[DATA_WIDTH-1:0];
        best_d  = '0;
        idx_d   = ACTIONS_WIDTH'(1);
        state_d = S_MAX;
      end
      S_MAX: begin
        // Strictly greater: ties keep the lowest action index.
        if (next_q_q[idx_q] > max_q) begin
          max_d  = next_q_q[idx_q];
          best_d = idx_q;
        end
        idx_d = idx_q + ACTIONS_WIDTH'(1);
        if (idx_q == ACTIONS_WIDTH'(ACTIONS - 1)) state_d = S_CALC;
      end
      S_CALC: begin
        data_d  = nq_sat;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d     = 1'b1;
        best_out_d = best_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      st_q       <= '0;
      at_q       <= '0;
      next_st_q  <= '0;
      reward_q   <= '0;
      cur_q_q    <= '0;
      // NOTE: the small s' value array is reset too, so no register ever holds stale data after reset.
      for (int k = 0; k < ACTIONS; k++) next_q_q[k] <= '0;
      max_q      <= '0;
      best_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      best_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      st_q       <= st_d;
      at_q       <= at_d;
      next_st_q  <= next_st_d;
      reward_q   <= reward_d;
      cur_q_q    <= cur_q_d;
      next_q_q   <= next_q_d;
      max_q      <= max_d;
      best_q     <= best_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      best_out_q <= best_out_d;
      done_q     <= done_d;
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_ram_re      = (state_q == S_READ);
  assign o_ram_we      = (state_q == S_WRITE);
  assign o_ram_at      = at_q;
  assign o_ram_st      = st_q;
  assign o_ram_next_st = next_st_q;
  assign o_ram_data    = data_q;
  assign o_done        = done_q;
  assign o_best_at     = best_out_q;

endmodule
